// File: rtl/img_cut_cfg_sched_pkg.sv
// Shared definitions for the edge-cut configuration scheduler.
//   - CFG_ADDR_*   : host shadow-register map
//   - mon_state_e  : video monitor state (also exported for debug)
//   - *_DEF        : default counter widths
package img_cut_pkg;

  localparam int CNT_W_DEF  = 12;
  localparam int FCNT_W_DEF = 16;

  localparam logic [1:0] CFG_ADDR_CTRL = 2'd0;  // {[1] oneshot, [0] enable}
  localparam logic [1:0] CFG_ADDR_COL  = 2'd1;
  localparam logic [1:0] CFG_ADDR_ROW  = 2'd2;
  localparam logic [1:0] CFG_ADDR_RSVD = 2'd3;  // writes ignored

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    IN_LINE  = 2'd1,
    LINE_GAP = 2'd2
  } mon_state_e;

endpackage

// File: rtl/img_cut_cfg_sched_if.sv
// Bundle of the scheduler's host/config, monitored stream and datapath
// outputs. The stream has no tready: every tvalid cycle is a consumed beat.
// Handshake: cfg_wr/cfg_commit/err_clr are single-cycle strobes taken on any
// rising edge where they are high; stream fields are only meaningful when
// s_axis_tvalid is high.
//   master : drives strobes/stream, observes outputs
//   slave  : the scheduler
interface img_cut_cfg_sched_if #(
  parameter int CNT_W  = img_cut_pkg::CNT_W_DEF,
  parameter int FCNT_W = img_cut_pkg::FCNT_W_DEF
) ();

  logic                   cfg_wr;
  logic [1:0]             cfg_addr;
  logic [CNT_W-1:0]       cfg_wdata;
  logic                   cfg_commit;
  logic                   err_clr;
  logic                   s_axis_tvalid;
  logic                   s_axis_tuser;
  logic                   s_axis_tlast;

  logic                   cut_enable;
  logic [CNT_W-1:0]       cut_column;
  logic [CNT_W-1:0]       cut_row;
  logic                   cfg_pending;
  logic [FCNT_W-1:0]      frame_count;
  logic                   err_cfg;
  logic                   err_line;
  logic                   err_frame;
  img_cut_pkg::mon_state_e dbg_state;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, cfg_commit, err_clr,
           s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    input  cut_enable, cut_column, cut_row, cfg_pending, frame_count,
           err_cfg, err_line, err_frame, dbg_state
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, cfg_commit, err_clr,
           s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    output cut_enable, cut_column, cut_row, cfg_pending, frame_count,
           err_cfg, err_line, err_frame, dbg_state
  );

endinterface

// File: rtl/img_cut_cfg_sched_monitor.sv
// Frame geometry monitor. Tracks beats per line and lines per frame of the
// monitored stream and emits single-cycle event pulses.
//   clk_i, rst_ni                 : clock, async active-low reset
//   tvalid_i, tuser_i, tlast_i    : monitored stream (sampled when tvalid_i)
//   sof_beat_o                    : SOF beat accepted this cycle
//   frame_done_o                  : EOL beat of the last line of a frame
//   line_len_err_o                : line ended with wrong length, or cut by SOF
//   frame_err_o                   : SOF arrived before the frame completed
//   state_o                       : current monitor state (debug)
module img_frame_monitor
  import img_cut_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tvalid_i,
  input  logic       tuser_i,
  input  logic       tlast_i,
  output logic       sof_beat_o,
  output logic       frame_done_o,
  output logic       line_len_err_o,
  output logic       frame_err_o,
  output mon_state_e state_o
);

  localparam logic [CNT_W-1:0] LINE_BEATS  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] FRAME_LINES = CNT_W'(IMG_HEIGHT);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;   // beats seen in the current line
  logic [CNT_W-1:0] line_q, line_d;   // completed lines in the current frame
  logic             first_q, first_d; // no SOF seen since reset

  logic             sof;
  logic             in_frame;
  logic [CNT_W-1:0] beats_now;
  logic [CNT_W-1:0] lines_now;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_SOF;
      beat_q  <= '0;
      line_q  <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    line_d         = line_q;
    first_d        = first_q;
    sof_beat_o     = 1'b0;
    frame_done_o   = 1'b0;
    line_len_err_o = 1'b0;
    frame_err_o    = 1'b0;
    beats_now      = '0;
    lines_now      = '0;
    sof            = tvalid_i & tuser_i;
    in_frame       = (state_q != WAIT_SOF);

    if (sof) begin
      sof_beat_o = 1'b1;
      first_d    = 1'b0;
      // A fresh frame after reset has no predecessor to be short.
      if (in_frame && !first_q) frame_err_o = 1'b1;
      if (state_q == IN_LINE)   line_len_err_o = 1'b1;
    end

    // Beats outside a frame (WAIT_SOF, no tuser) are ignored. An SOF beat
    // restarts both counters and is itself beat 1 of line 0.
    if (tvalid_i && (sof || in_frame)) begin
      if (sof || state_q == LINE_GAP) beats_now = CNT_W'(1);
      else if (beat_q == '1)          beats_now = beat_q;   // saturate
      else                            beats_now = beat_q + CNT_W'(1);
      lines_now = sof ? '0 : line_q;

      if (tlast_i) begin
        if (beats_now != LINE_BEATS) line_len_err_o = 1'b1;
        if (lines_now != '1) lines_now = lines_now + CNT_W'(1);
        beat_d = '0;
        if (lines_now == FRAME_LINES) begin
          frame_done_o = 1'b1;
          state_d      = WAIT_SOF;
          line_d       = '0;
        end else begin
          state_d = LINE_GAP;
          line_d  = lines_now;
        end
      end else begin
        state_d = IN_LINE;
        beat_d  = beats_now;
        line_d  = lines_now;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/img_cut_cfg_sched.sv
// Frame-synchronous configuration scheduler for the edge-cut datapath.
// Host writes land in shadow registers; a commit is applied atomically on the
// next SOF beat after validating the cut geometry. Sticky error flags report
// bad configs, bad line lengths and short frames.
//   s_axis_aclk    : clock
//   s_axis_aresetn : async active-low reset
//   bus            : config strobes, monitored stream, active outputs
module img_cut_cfg_sched
  import img_cut_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FCNT_W     = FCNT_W_DEF
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_aresetn,
  img_cut_cfg_sched_if.slave  bus
);

  // Limits in CNT_W+1 bits so that 2*cut never overflows the compare.
  localparam logic [CNT_W:0] COL_LIM = (CNT_W+1)'(IMG_WIDTH);
  localparam logic [CNT_W:0] ROW_LIM = (CNT_W+1)'(IMG_HEIGHT);

  logic              sof_beat, frame_done, line_len_err, frame_err;
  mon_state_e        mon_state;

  logic [1:0]        sh_ctrl_q, sh_ctrl_d;
  logic [CNT_W-1:0]  sh_col_q, sh_col_d;
  logic [CNT_W-1:0]  sh_row_q, sh_row_d;
  logic              pend_q, pend_d;
  logic              en_q, en_d;
  logic              os_q, os_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [FCNT_W-1:0] fc_q, fc_d;
  logic              err_cfg_q, err_cfg_d;
  logic              err_line_q, err_line_d;
  logic              err_frame_q, err_frame_d;

  logic              apply;
  logic              cfg_ok;

  img_frame_monitor #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .CNT_W      (CNT_W)
  ) u_mon (
    .clk_i          (s_axis_aclk),
    .rst_ni         (s_axis_aresetn),
    .tvalid_i       (bus.s_axis_tvalid),
    .tuser_i        (bus.s_axis_tuser),
    .tlast_i        (bus.s_axis_tlast),
    .sof_beat_o     (sof_beat),
    .frame_done_o   (frame_done),
    .line_len_err_o (line_len_err),
    .frame_err_o    (frame_err),
    .state_o        (mon_state)
  );

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      sh_ctrl_q   <= '0;
      sh_col_q    <= '0;
      sh_row_q    <= '0;
      pend_q      <= 1'b0;
      en_q        <= 1'b0;
      os_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      fc_q        <= '0;
      err_cfg_q   <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      sh_ctrl_q   <= sh_ctrl_d;
      sh_col_q    <= sh_col_d;
      sh_row_q    <= sh_row_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      os_q        <= os_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fc_q        <= fc_d;
      err_cfg_q   <= err_cfg_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  // Apply uses the registered shadow, so a write on the SOF cycle itself
  // belongs to the next commit.
  assign apply  = sof_beat & pend_q;
  assign cfg_ok = ({sh_col_q, 1'b0} < COL_LIM) && ({sh_row_q, 1'b0} < ROW_LIM);

  always_comb begin
    sh_ctrl_d = sh_ctrl_q;
    sh_col_d  = sh_col_q;
    sh_row_d  = sh_row_q;
    pend_d    = pend_q;
    en_d      = en_q;
    os_d      = os_q;
    col_d     = col_q;
    row_d     = row_q;

    if (bus.cfg_wr) begin
      case (bus.cfg_addr)
        CFG_ADDR_CTRL: sh_ctrl_d = bus.cfg_wdata[1:0];
        CFG_ADDR_COL:  sh_col_d  = bus.cfg_wdata;
        CFG_ADDR_ROW:  sh_row_d  = bus.cfg_wdata;
        default:       ;
      endcase
    end

    // The SOF consumes the pending commit; a commit on that same cycle
    // re-arms for the following SOF.
    if (apply)          pend_d = 1'b0;
    if (bus.cfg_commit) pend_d = 1'b1;

    if (frame_done && os_q) en_d = 1'b0;

    if (apply && cfg_ok) begin
      en_d  = sh_ctrl_q[0];
      os_d  = sh_ctrl_q[1];
      col_d = sh_col_q;
      row_d = sh_row_q;
    end

    fc_d = fc_q + FCNT_W'(frame_done);

    // New error sets override a same-cycle clear so nothing is lost.
    err_cfg_d   = (err_cfg_q   & ~bus.err_clr) | (apply & ~cfg_ok);
    err_line_d  = (err_line_q  & ~bus.err_clr) | line_len_err;
    err_frame_d = (err_frame_q & ~bus.err_clr) | frame_err;
  end

  assign bus.cut_enable  = en_q;
  assign bus.cut_column  = col_q;
  assign bus.cut_row     = row_q;
  assign bus.cfg_pending = pend_q;
  assign bus.frame_count = fc_q;
  assign bus.err_cfg     = err_cfg_q;
  assign bus.err_line    = err_line_q;
  assign bus.err_frame   = err_frame_q;
  assign bus.dbg_state   = mon_state;

endmodule

// File: tb/tb_img_cut_cfg_sched.sv
// Bench for img_cut_cfg_sched with a reduced 16x12 geometry so full frames
// stay short. Expected outputs come from a transaction-level model built from
// the frame/line/commit rules.
module tb_img_cut_cfg_sched;
  import img_cut_pkg::*;

  localparam int W      = 16;
  localparam int H      = 12;
  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;
  localparam int VW     = 1 + CNT_W + CNT_W + 1 + FCNT_W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  img_cut_cfg_sched_if #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) bus ();

  img_cut_cfg_sched #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .CNT_W      (CNT_W),
    .FCNT_W     (FCNT_W)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .bus            (bus)
  );

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.cut_enable, bus.cut_column, bus.cut_row, bus.cfg_pending,
                    bus.frame_count, bus.err_cfg, bus.err_line, bus.err_frame};

  int vectors = 0;
  int miscompares = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got_q[$];

  // ---------------- reference model ----------------
  int m_sh_ctrl, m_sh_col, m_sh_row;
  bit m_pend, m_en, m_os;
  int m_col, m_row, m_fc;
  bit m_ecfg, m_eline, m_eframe;
  bit m_in_frame;
  int m_pos, m_lines;

  function automatic logic [VW-1:0] exp_vec();
    return {m_en, 12'(m_col), 12'(m_row), m_pend, 16'(m_fc), m_ecfg, m_eline, m_eframe};
  endfunction

  task automatic model_reset();
    m_sh_ctrl = 0; m_sh_col = 0; m_sh_row = 0;
    m_pend = 0; m_en = 0; m_os = 0; m_col = 0; m_row = 0; m_fc = 0;
    m_ecfg = 0; m_eline = 0; m_eframe = 0;
    m_in_frame = 0; m_pos = 0; m_lines = 0;
  endtask

  task automatic model_cycle(input bit v, u, l, wr, input logic [1:0] a,
                             input int d, input bit cm, clr);
    if (clr) begin m_ecfg = 0; m_eline = 0; m_eframe = 0; end
    if (v && u) begin
      if (m_in_frame) begin
        m_eframe = 1;
        if (m_pos > 0) m_eline = 1;
      end
      if (m_pend) begin
        if (2 * m_sh_col < W && 2 * m_sh_row < H) begin
          m_en = m_sh_ctrl[0]; m_os = m_sh_ctrl[1];
          m_col = m_sh_col; m_row = m_sh_row;
        end else m_ecfg = 1;
        m_pend = 0;
      end
      m_in_frame = 1; m_lines = 0; m_pos = 0;
    end
    if (v && m_in_frame) begin
      m_pos++;
      if (l) begin
        if (m_pos != W) m_eline = 1;
        m_lines++;
        m_pos = 0;
        if (m_lines == H) begin
          m_fc = (m_fc + 1) % 65536;
          m_in_frame = 0;
          if (m_os) m_en = 0;
        end
      end
    end
    if (cm) m_pend = 1;
    if (wr) begin
      case (a)
        2'd0: m_sh_ctrl = d & 3;
        2'd1: m_sh_col  = d;
        2'd2: m_sh_row  = d;
        default: ;
      endcase
    end
  endtask

  // ---------------- drivers ----------------
  // One clock of stimulus; called and returns at a falling edge, so outputs
  // seen afterwards reflect the rising edge that sampled these inputs.
  task automatic cyc(input bit v, u, l, wr, input logic [1:0] a, input int d,
                     input bit cm, clr);
    bus.s_axis_tvalid = v;
    bus.s_axis_tuser  = v ? u : 1'($urandom_range(0, 1));
    bus.s_axis_tlast  = v ? l : 1'($urandom_range(0, 1));
    bus.cfg_wr        = wr;
    bus.cfg_addr      = a;
    bus.cfg_wdata     = CNT_W'(d);
    bus.cfg_commit    = cm;
    bus.err_clr       = clr;
    model_cycle(v, u, l, wr, a, d, cm, clr);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic wr(input logic [1:0] a, input int d);
    cyc(0, 0, 0, 1, a, d, 0, 0);
  endtask

  task automatic commit();
    cyc(0, 0, 0, 0, 2'd0, 0, 1, 0);
  endtask

  task automatic beat(input bit u, l);
    int gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) idle();
    cyc(1, u, l, 0, 2'd0, 0, 0, 0);
  endtask

  task automatic send_line(input int len, input bit sof);
    for (int i = 0; i < len; i++) beat(sof && i == 0, i == len - 1);
  endtask

  task automatic send_lines(input int n);
    for (int i = 0; i < n; i++) send_line(W, 0);
  endtask

  task automatic send_frame();
    send_line(W, 1);
    send_lines(H - 1);
  endtask

  task automatic do_reset();
    bus.s_axis_tvalid = 0; bus.s_axis_tuser = 0; bus.s_axis_tlast = 0;
    bus.cfg_wr = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.cfg_commit = 0; bus.err_clr = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_vec !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    vectors++;
    if (bus.dbg_state !== WAIT_SOF) begin
      miscompares++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, WAIT_SOF);
    end
  endtask

  task automatic test_apply();
    do_reset();
    wr(2'd1, 2);
    wr(2'd2, 3);
    cyc(0, 0, 0, 1, 2'd0, 1, 1, 0);  // CTRL write together with commit
    idle();
    vectors++;
    if ({bus.cut_enable, bus.cut_column, bus.cut_row, bus.cfg_pending} !== {1'b0, 12'd0, 12'd0, 1'b1}) begin
      miscompares++; $display("FAIL apply_before_sof: got %h want pending only", dut_vec);
    end
    beat(1, 0);
    vectors++;
    if ({bus.cut_enable, bus.cut_column, bus.cut_row, bus.cfg_pending} !== {1'b1, 12'd2, 12'd3, 1'b0}) begin
      miscompares++; $display("FAIL apply_after_sof: got %h want en=1 col=2 row=3", dut_vec);
    end
    vectors++;
    if (bus.dbg_state !== IN_LINE) begin
      miscompares++; $display("FAIL apply_state: got %0d want %0d", bus.dbg_state, IN_LINE);
    end
    for (int i = 1; i < W; i++) beat(0, i == W - 1);
    send_lines(H - 1);
    vectors++;
    if (dut_vec !== exp_vec() || bus.frame_count !== 16'd1) begin
      miscompares++; $display("FAIL apply_frame_end: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_invalid_cfg();
    int r;
    wr(2'd1, W / 2);  // 2*col == width: rejected
    commit();
    send_frame();
    vectors++;
    if ({bus.err_cfg, bus.cut_column, bus.cut_row, bus.cfg_pending} !== {1'b1, 12'd2, 12'd3, 1'b0}
        || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL invalid_col: got %h want %h", dut_vec, exp_vec());
    end
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 1);
    vectors++;
    if (bus.err_cfg !== 1'b0) begin
      miscompares++; $display("FAIL err_cfg_clear: got %b want 0", bus.err_cfg);
    end
    wr(2'd1, W / 2 - 1);
    wr(2'd2, H / 2 - 1);
    commit();
    send_frame();
    vectors++;
    if ({bus.err_cfg, bus.cut_column, bus.cut_row} !== {1'b0, 12'(W / 2 - 1), 12'(H / 2 - 1)}
        || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL boundary_valid: got %h want %h", dut_vec, exp_vec());
    end
    r = $urandom_range(H / 2, 4095);
    wr(2'd2, r);
    commit();
    send_frame();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL invalid_row_%0d: got %h want %h", r, dut_vec, exp_vec());
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(2'd1, $urandom_range(0, W / 2 - 1));
    wr(2'd2, $urandom_range(0, H / 2 - 1));
    wr(2'd0, 3);
    commit();
    send_line(W, 1);
    send_lines(H - 2);
    for (int i = 0; i < W - 1; i++) beat(0, 0);
    vectors++;
    if (bus.cut_enable !== 1'b1 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL oneshot_during: got %h want %h", dut_vec, exp_vec());
    end
    beat(0, 1);
    vectors++;
    if (bus.cut_enable !== 1'b0 || bus.frame_count !== 16'd1 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL oneshot_after_eol: got %h want %h", dut_vec, exp_vec());
    end
    send_frame();
    vectors++;
    if (bus.cut_enable !== 1'b0 || bus.frame_count !== 16'd2 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL oneshot_second: got %h want %h", dut_vec, exp_vec());
    end
    commit();
    beat(1, 0);
    vectors++;
    if (bus.cut_enable !== 1'b1 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL oneshot_rearm: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_line_err();
    do_reset();
    send_line(W, 1);
    vectors++;
    if (bus.err_line !== 1'b0) begin
      miscompares++; $display("FAIL line_ok: got %b want 0", bus.err_line);
    end
    send_line(W - 1, 0);
    vectors++;
    if (bus.err_line !== 1'b1 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL line_short: got %h want %h", dut_vec, exp_vec());
    end
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 1);
    vectors++;
    if (bus.err_line !== 1'b0) begin
      miscompares++; $display("FAIL line_clear: got %b want 0", bus.err_line);
    end
    for (int i = 0; i < W - 2; i++) beat(0, 0);
    cyc(1, 0, 1, 0, 2'd0, 0, 0, 1);  // short EOL and clear on one edge
    vectors++;
    if (bus.err_line !== 1'b1) begin
      miscompares++; $display("FAIL line_set_wins: got %b want 1", bus.err_line);
    end
    send_line(W + 1, 0);
    send_lines(H - 4);
    vectors++;
    if (bus.frame_count !== 16'd1 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL line_frame_end: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    send_frame();
    send_line(W, 1);
    send_lines(4);
    vectors++;
    if (bus.err_frame !== 1'b0) begin
      miscompares++; $display("FAIL short_before: got %b want 0", bus.err_frame);
    end
    beat(1, 0);
    vectors++;
    if ({bus.err_frame, bus.err_line, bus.frame_count} !== {1'b1, 1'b0, 16'd1}) begin
      miscompares++; $display("FAIL short_sof: got %h want err_frame=1 fc=1", dut_vec);
    end
    for (int i = 1; i < W; i++) beat(0, i == W - 1);
    send_lines(H - 1);
    vectors++;
    if (bus.frame_count !== 16'd2 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL short_recover: got %h want %h", dut_vec, exp_vec());
    end
    cyc(0, 0, 0, 0, 2'd0, 0, 0, 1);
    send_line(W, 1);
    for (int i = 0; i < 3; i++) beat(0, 0);
    beat(1, 0);
    vectors++;
    if ({bus.err_frame, bus.err_line} !== 2'b11 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL midline_sof: got %h want %h", dut_vec, exp_vec());
    end
    for (int i = 1; i < W; i++) beat(0, i == W - 1);
    send_lines(H - 1);
    vectors++;
    if (bus.frame_count !== 16'd3 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL midline_recover: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_commit_on_sof();
    do_reset();
    wr(2'd1, 5);
    wr(2'd2, 4);
    wr(2'd0, 1);
    cyc(1, 1, 0, 0, 2'd0, 0, 1, 0);  // commit on the SOF beat
    vectors++;
    if ({bus.cut_enable, bus.cfg_pending} !== 2'b01 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL commit_on_sof: got %h want %h", dut_vec, exp_vec());
    end
    for (int i = 1; i < W; i++) beat(0, i == W - 1);
    commit();  // repeated commit while pending
    send_lines(H - 1);
    beat(1, 0);
    vectors++;
    if ({bus.cut_enable, bus.cut_column, bus.cut_row, bus.cfg_pending} !== {1'b1, 12'd5, 12'd4, 1'b0}) begin
      miscompares++; $display("FAIL commit_next_sof: got %h want en=1 col=5 row=4", dut_vec);
    end
  endtask

  task automatic test_random();
    int nlines, len;
    logic [VW-1:0] e, g;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 1)) wr(2'd1, $urandom_range(0, W));
      if ($urandom_range(0, 1)) wr(2'd2, $urandom_range(0, H));
      if ($urandom_range(0, 1)) wr(2'd0, $urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) commit();
      if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 2'd0, 0, 0, 1);
      nlines = ($urandom_range(0, 3) == 0) ? $urandom_range(2, H - 1) : H;
      for (int l = 0; l < nlines; l++) begin
        case ($urandom_range(0, 7))
          0:       len = W - 1;
          1:       len = W + 1;
          default: len = W;
        endcase
        send_line(len, l == 0);
        exp_q.push_back(exp_vec());
        got_q.push_back(dut_vec);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++; $display("FAIL random_line: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(2'd1, 3);
    wr(2'd0, 1);
    commit();
    send_line(W, 1);
    wr(2'd1, 6);
    commit();
    for (int i = 0; i < 5; i++) beat(0, 0);
    #2 rst_n = 0;
    #1;
    vectors++;
    if (dut_vec !== '0 || bus.dbg_state !== WAIT_SOF) begin
      miscompares++; $display("FAIL reset_mid_outputs: got %h want 0", dut_vec);
    end
    do_reset();
    send_frame();
    vectors++;
    if (dut_vec !== {1'b0, 12'd0, 12'd0, 1'b0, 16'd1, 3'b000} || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL reset_mid_clean: got %h want fc=1 only", dut_vec);
    end
  endtask

  initial begin
    test_reset();
    test_apply();
    test_invalid_cfg();
    test_oneshot();
    test_line_err();
    test_short_frame();
    test_commit_on_sof();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
